// File: rtl/sw_debounce.sv
// Switch input conditioner: two-flop synchroniser on the active-low pins, then a per-channel
// debounce counter with registered press/release pulses. Define SW_DEBOUNCE_TOGGLE_EN to add o_sw_toggle.
module sw_debounce #(
  parameter int N_SW            = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_SW-1:0] i_sw_n,
  output logic [N_SW-1:0] o_sw_level,
  output logic [N_SW-1:0] o_sw_press,
`ifdef SW_DEBOUNCE_TOGGLE_EN
  output logic [N_SW-1:0] o_sw_toggle,
`endif
  output logic [N_SW-1:0] o_sw_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_SW-1:0] sync1_reg;
  logic [N_SW-1:0] sync2_reg;
  logic [N_SW-1:0] sw_s;

  // Reset to all-ones so a released switch never looks like a press on the way out of reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_reg <= '1;
      sync2_reg <= '1;
    end else begin
      sync1_reg <= i_sw_n;
      sync2_reg <= sync1_reg;
    end
  end

  assign sw_s = ~sync2_reg;

  generate
    for (genvar gi = 0; gi < N_SW; gi++) begin : g_chan
      logic [CNT_W-1:0] cnt_reg;
      logic             level_reg;
      logic             press_reg;
      logic             release_reg;
`ifdef SW_DEBOUNCE_TOGGLE_EN
      logic             toggle_reg;
`endif

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          cnt_reg     <= '0;
          level_reg   <= 1'b0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
`ifdef SW_DEBOUNCE_TOGGLE_EN
          toggle_reg  <= 1'b0;
`endif
        end else begin
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
`ifdef SW_DEBOUNCE_TOGGLE_EN
          toggle_reg  <= toggle_reg ^ press_reg;
`endif
          if (sw_s[gi] == level_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_MAX) begin
            // Input has disagreed with the level for the full window: accept it.
            level_reg   <= sw_s[gi];
            cnt_reg     <= '0;
            press_reg   <= sw_s[gi];
            release_reg <= ~sw_s[gi];
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      end

      assign o_sw_level[gi]   = level_reg;
      assign o_sw_press[gi]   = press_reg;
      assign o_sw_release[gi] = release_reg;
`ifdef SW_DEBOUNCE_TOGGLE_EN
      assign o_sw_toggle[gi]  = toggle_reg;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce (DEBOUNCE_CYCLES=4): stimulus queues expected pulse events,
// a negedge monitor pops one whenever a press/release pulse appears. Toggle checks need SW_DEBOUNCE_TOGGLE_EN.
module tb_sw_debounce;
  localparam int N = 4;
  localparam int D = 4;
  localparam int LAT = 2 + D;  // drive after negedge of cycle c -> pulse visible at cycle c+LAT

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] sw_n = 4'b1111;
  logic [N-1:0] level, press, rel;
`ifdef SW_DEBOUNCE_TOGGLE_EN
  logic [N-1:0] toggle;
`endif

  sw_debounce #(.N_SW(N), .DEBOUNCE_CYCLES(D)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_sw_n       (sw_n),
    .o_sw_level   (level),
    .o_sw_press   (press),
`ifdef SW_DEBOUNCE_TOGGLE_EN
    .o_sw_toggle  (toggle),
`endif
    .o_sw_release (rel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  // Monitor: every pulse the DUT presents must match the next queued event exactly.
  always @(negedge clk) begin
    ev_t e;
    if ((press | rel) != '0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse cyc=%0d got press=%b release=%b level=%b, required no pulse",
                 cyc, press, rel, level);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.level !== level || e.press !== press || e.rel !== rel) begin
          n_err++;
          $display("FAIL pulse_event got cyc=%0d level=%b press=%b release=%b, required cyc=%0d level=%b press=%b release=%b",
                   cyc, level, press, rel, e.cyc, e.level, e.press, e.rel);
        end else begin
          $display("ok   pulse_event cyc=%0d level=%b press=%b release=%b", cyc, level, press, rel);
        end
      end
    end
  end

  task automatic push_ev(input logic [N-1:0] lv, input logic [N-1:0] pr, input logic [N-1:0] rl);
    ev_t e;
    e.cyc = cyc + LAT;
    e.level = lv;
    e.press = pr;
    e.rel = rl;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [N-1:0] v);
    @(negedge clk);
    sw_n = v;
  endtask

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s cyc=%0d got %b required %b", name, cyc, got, req);
    end else begin
      $display("ok   %s cyc=%0d value %b", name, cyc, got);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset, then idle
    repeat (3) @(negedge clk);
    check("reset_outputs", {level, press, rel}, 12'h000);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs", {level, press, rel}, 12'h000);
    end

    // 2: clean press and release on bit 0
    drive(4'b1110);
    push_ev(4'b0001, 4'b0001, 4'b0000);
    repeat (10) @(negedge clk);
    check("level_after_press0", {8'h00, level}, {8'h00, 4'b0001});
    sw_n = 4'b1111;
    push_ev(4'b0000, 4'b0000, 4'b0001);
    repeat (10) @(negedge clk);
    check("level_after_release0", {8'h00, level}, 12'h000);

    // 3: bounce of D-1 cycles on bit 1 must be rejected
    drive(4'b1101);
    repeat (3) @(negedge clk);
    sw_n = 4'b1111;
    repeat (10) @(negedge clk);
    check("bounce_rejected", {level, press, rel}, 12'h000);

    // 4: two bits change together
    drive(4'b0101);
    push_ev(4'b1010, 4'b1010, 4'b0000);
    repeat (10) @(negedge clk);
    check("level_multi_press", {8'h00, level}, {8'h00, 4'b1010});
    sw_n = 4'b1111;
    push_ev(4'b0000, 4'b0000, 4'b1010);
    repeat (10) @(negedge clk);

    // 5: reset mid-count, then reset while level is high
    drive(4'b1011);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_midcount", {level, press, rel}, 12'h000);
    rst = 1'b0;
    push_ev(4'b0100, 4'b0100, 4'b0000);
    repeat (12) @(negedge clk);
    check("level_after_requal", {8'h00, level}, {8'h00, 4'b0100});
    rst = 1'b1;
    @(negedge clk);
    check("reset_clears_level", {level, press, rel}, 12'h000);
    rst = 1'b0;
    push_ev(4'b0100, 4'b0100, 4'b0000);
    repeat (12) @(negedge clk);
    sw_n = 4'b1111;
    push_ev(4'b0000, 4'b0000, 4'b0100);
    repeat (10) @(negedge clk);

`ifdef SW_DEBOUNCE_TOGGLE_EN
    // 6: toggle on bit 3 across three presses
    for (int k = 0; k < 3; k++) begin
      drive(4'b0111);
      push_ev(4'b1000, 4'b1000, 4'b0000);
      repeat (9) @(negedge clk);
      check("toggle_after_press", {11'h000, toggle[3]}, {11'h000, (k % 2 == 0)});
      sw_n = 4'b1111;
      push_ev(4'b0000, 4'b0000, 4'b1000);
      repeat (9) @(negedge clk);
      check("toggle_after_release", {11'h000, toggle[3]}, {11'h000, (k % 2 == 0)});
    end
`endif

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_events got %0d outstanding, required 0", exp_q.size());
    end else begin
      $display("ok   all_events_seen");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
